// File: rtl/io_write_port_buffer.sv
// Per-port write-side FIFOs for memory-mapped I/O output ports; EmptyFull reserves LOOKAHEAD slots.
// Optional same-cycle write-through bypass to an empty, acking port: define IO_WRITE_BYPASS_EN.
module io_write_port_buffer #(
  parameter int WORD_WIDTH      = 36,
  parameter int ADDR_WIDTH      = 10,
  parameter int PORT_COUNT      = 4,
  parameter int PORT_ADDR_WIDTH = 2,
  parameter int DEPTH           = 4,
  parameter int LOOKAHEAD       = 3
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             wren,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [WORD_WIDTH-1:0]            wdata,
  output logic [PORT_COUNT-1:0]            EmptyFull,
  output logic [PORT_COUNT*WORD_WIDTH-1:0] port_data,
  output logic [PORT_COUNT-1:0]            port_valid,
  input  logic [PORT_COUNT-1:0]            port_ack,
  output logic [PORT_COUNT-1:0]            overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]      rd_ptr     [PORT_COUNT];
  logic [PTR_W-1:0]      wr_ptr     [PORT_COUNT];
  logic [CNT_W-1:0]      count      [PORT_COUNT];
  logic [CNT_W-1:0]      count_next [PORT_COUNT];
  logic [WORD_WIDTH-1:0] mem        [PORT_COUNT][DEPTH];

  logic [PORT_COUNT-1:0]      hit, push, pop, drop, bypass;
  logic [PORT_COUNT-1:0]      valid_q, full_q, ovf_q;
  logic [PORT_ADDR_WIDTH-1:0] idx;
  logic                       addr_unused;

  // Only the low address bits select a port; the rest are decoded upstream.
  assign addr_unused = ^addr[ADDR_WIDTH-1:PORT_ADDR_WIDTH];
  assign idx         = addr[PORT_ADDR_WIDTH-1:0];

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    hit    = '0;
    push   = '0;
    pop    = '0;
    drop   = '0;
    bypass = '0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      count_next[p] = count[p];
      // Indices >= PORT_COUNT match no port, so such writes vanish silently.
      hit[p]  = wren && (int'(idx) == p);
      pop[p]  = port_ack[p] && valid_q[p];
      drop[p] = hit[p] && (int'(count[p]) == DEPTH) && !pop[p];
`ifdef IO_WRITE_BYPASS_EN
      bypass[p] = hit[p] && !valid_q[p] && port_ack[p];
`endif
      push[p] = hit[p] && !drop[p] && !bypass[p];
      if (push[p] && !pop[p]) begin
        count_next[p] = count[p] + CNT_W'(1);
      end else if (pop[p] && !push[p]) begin
        count_next[p] = count[p] - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        count[p]  <= '0;
      end
      valid_q <= '0;
      full_q  <= '0;
      ovf_q   <= '0;
    end else begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
        count[p]   <= count_next[p];
        valid_q[p] <= (count_next[p] != '0);
        // Hold back LOOKAHEAD slots for writes already past the predication check.
        full_q[p]  <= (DEPTH - int'(count_next[p])) < LOOKAHEAD;
        if (drop[p]) ovf_q[p] <= 1'b1;
      end
    end
  end

  // NOTE: the storage array is not reset; stale words are never visible because reads are gated by valid.
  always_ff @(posedge clock) begin
    for (int p = 0; p < PORT_COUNT; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= wdata;
    end
  end

  always_comb begin
    port_data  = '0;
    port_valid = valid_q;
    for (int p = 0; p < PORT_COUNT; p++) begin
      if (valid_q[p]) port_data[p*WORD_WIDTH +: WORD_WIDTH] = mem[p][rd_ptr[p]];
`ifdef IO_WRITE_BYPASS_EN
      if (bypass[p]) begin
        port_valid[p]                         = 1'b1;
        port_data[p*WORD_WIDTH +: WORD_WIDTH] = wdata;
      end
`endif
    end
  end

  assign EmptyFull = full_q;
  assign overflow  = ovf_q;

endmodule
